// File: rtl/line_ram_ctrl.sv
// Line-wide BRAM controller: valid/ready requests, in-order read responses, word-granular programming port.
// Reads respond RD_LATENCY cycles after accept; req_ready_o throttles so the response FIFO never overflows.
module line_ram_ctrl #(
  parameter int LINE_WIDTH = 128,
  parameter int WORD_WIDTH = 32,
  parameter int LINE_DEPTH = 8192,
  parameter int RD_LATENCY = 1,
  localparam int WPL  = LINE_WIDTH / WORD_WIDTH,
  localparam int LA_W = $clog2(LINE_DEPTH),
  localparam int WA_W = LA_W + $clog2(WPL)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic                    req_we_i,
  input  logic [LA_W-1:0]         req_addr_i,
  input  logic [LINE_WIDTH-1:0]   req_wdata_i,
  input  logic [LINE_WIDTH/8-1:0] req_wstrb_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [LINE_WIDTH-1:0]   rsp_rdata_o,
  input  logic                    prog_mode_i,
  input  logic                    prog_valid_i,
  input  logic [WA_W-1:0]         prog_addr_i,
  input  logic [WORD_WIDTH-1:0]   prog_data_i,
  output logic                    prog_ack_o,
  output logic                    busy_o
);

  localparam int NB = LINE_WIDTH / 8;
  localparam int WB = WORD_WIDTH / 8;
  localparam int FD = RD_LATENCY + 1;
  localparam int PW = $clog2(FD);
  localparam int CW = $clog2(FD + 1);
  localparam logic [CW-1:0] FD_C     = CW'(FD);
  localparam logic [PW-1:0] PTR_LAST = PW'(FD - 1);

  logic [LINE_WIDTH-1:0] mem_q [LINE_DEPTH];
  logic                  mem_we;
  logic [LA_W-1:0]       mem_addr;
  logic [LINE_WIDTH-1:0] mem_wdata;
  logic [NB-1:0]         mem_strb;
  int                    prog_word;

  logic wr_acc, rd_acc, prog_wr, rsp_pop;

  logic                  s1_vld_q, s1_vld_d;
  logic [LINE_WIDTH-1:0] s1_dat_q;
  logic                  pipe_vld;
  logic [LINE_WIDTH-1:0] pipe_dat;

  logic [LINE_WIDTH-1:0] fifo_q [FD];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         fifo_cnt_q, fifo_cnt_d;
  logic [CW-1:0]         out_cnt_q, out_cnt_d;
  logic                  fifo_push, fifo_pop, fifo_vld;
  logic                  prog_ack_q, prog_ack_d;

  // Credit is the count of reads in the pipe or FIFO, so a full FIFO can always absorb the pipe.
  assign req_ready_o = rst_ni && !prog_mode_i && (out_cnt_q < FD_C);
  assign wr_acc      = req_valid_i && req_ready_o && req_we_i;
  assign rd_acc      = req_valid_i && req_ready_o && !req_we_i;
  assign prog_wr     = prog_mode_i && prog_valid_i;
  assign busy_o      = (out_cnt_q != '0);
  assign prog_ack_o  = prog_ack_q;

  // Single write port shared by the request channel and the programmer; they never overlap.
  always_comb begin
    prog_word = int'(prog_addr_i) % WPL;
    mem_we    = prog_wr || wr_acc;
    mem_addr  = req_addr_i;
    mem_wdata = req_wdata_i;
    mem_strb  = req_wstrb_i;
    if (prog_wr) begin
      mem_addr  = prog_addr_i[WA_W-1 -: LA_W];
      mem_wdata = {WPL{prog_data_i}};
      for (int b = 0; b < NB; b++) mem_strb[b] = ((b / WB) == prog_word);
    end
  end

  always_ff @(posedge clk_i) begin
    for (int b = 0; b < NB; b++)
      if (mem_we && mem_strb[b]) mem_q[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    if (rd_acc) s1_dat_q <= mem_q[req_addr_i];
  end

  generate
    if (RD_LATENCY == 2) begin : g_lat2
      logic                  s2_vld_q;
      logic [LINE_WIDTH-1:0] s2_dat_q;
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) s2_vld_q <= 1'b0;
        else         s2_vld_q <= s1_vld_q;
      end
      always_ff @(posedge clk_i) s2_dat_q <= s1_dat_q;
      assign pipe_vld = s2_vld_q;
      assign pipe_dat = s2_dat_q;
    end else begin : g_lat1
      assign pipe_vld = s1_vld_q;
      assign pipe_dat = s1_dat_q;
    end
  endgenerate

  // Pipe output bypasses an empty FIFO; it is parked in the FIFO only when it cannot leave now.
  always_comb begin
    s1_vld_d    = rd_acc;
    fifo_vld    = (fifo_cnt_q != '0);
    rsp_valid_o = fifo_vld || pipe_vld;
    rsp_rdata_o = fifo_vld ? fifo_q[rd_ptr_q] : pipe_dat;
    rsp_pop     = rsp_valid_o && rsp_ready_i;
    fifo_pop    = fifo_vld && rsp_ready_i;
    fifo_push   = pipe_vld && (fifo_vld || !rsp_ready_i);
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    if (fifo_push) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PW'(1);
    if (fifo_pop)  rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PW'(1);
    fifo_cnt_d  = fifo_cnt_q + CW'(fifo_push) - CW'(fifo_pop);
    out_cnt_d   = out_cnt_q + CW'(rd_acc) - CW'(rsp_pop);
    prog_ack_d  = prog_wr;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_vld_q   <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      out_cnt_q  <= '0;
      prog_ack_q <= 1'b0;
    end else begin
      s1_vld_q   <= s1_vld_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
      out_cnt_q  <= out_cnt_d;
      prog_ack_q <= prog_ack_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (fifo_push) fifo_q[wr_ptr_q] <= pipe_dat;
  end

  a_params: assert property (@(posedge clk_i)
    (RD_LATENCY == 1 || RD_LATENCY == 2) && (LINE_WIDTH % WORD_WIDTH == 0));
  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(fifo_push && fifo_cnt_q == FD_C));
  a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(rsp_pop && out_cnt_q == '0));

endmodule
